// File: rtl/calc_sequencer.sv
//==============================================================================
// Module   : calc_sequencer
// Purpose  : Calculator control stage that drives an external 4-bit adder
//            through add/sub, shift-add multiply, repeated-subtract divide,
//            and owns the memory register.
// Revision : 1.0 - initial release
//==============================================================================
`default_nettype none

module calc_sequencer #(
  parameter logic [7:0] MEM_INIT = 8'h00
) (
  input  logic       clk,
  input  logic       rstN,
  input  logic       start,
  input  logic [1:0] opcode,
  input  logic [3:0] operandA,
  input  logic [3:0] operandB,
  input  logic [1:0] memCmd,
  output logic [3:0] addOperand1,
  output logic [3:0] addOperand2,
  output logic       addOperation,
  output logic       addCarryIn,
  input  logic [3:0] addSum,
  input  logic       addCarryOut,
  output logic       busy,
  output logic       done,
  output logic [7:0] result,
  output logic       negative,
  output logic       errDivZero
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_ADDSUB = 3'd1,
    S_MUL    = 3'd2,
    S_DIV    = 3'd3,
    S_DONE   = 3'd4
  } state_t;

  localparam logic [1:0] c_MEM_STORE  = 2'b01;
  localparam logic [1:0] c_MEM_RECALL = 2'b10;
  localparam logic [1:0] c_MEM_CLEAR  = 2'b11;

  state_t     r_state, w_next;
  logic       r_sub;
  logic [3:0] r_a, r_b;
  logic [3:0] r_hi;    // Phi during multiply, remainder during divide
  logic [3:0] r_lo;    // Plo during multiply, quotient during divide
  logic [1:0] r_step;
  logic [7:0] r_result, r_mem;
  logic       r_neg, r_err;

  logic       w_mc;
  logic [3:0] w_ms;
  logic [8:0] w_shift;

  // State register
  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  // Next state and adder drive
  always_comb begin
    w_next       = r_state;
    addOperand1  = 4'h0;
    addOperand2  = 4'h0;
    addOperation = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (start) begin
          if (!opcode[1])          w_next = S_ADDSUB;
          else if (opcode == 2'b10) w_next = S_MUL;
          else                      w_next = S_DIV;
        end else if (memCmd == c_MEM_RECALL) begin
          w_next = S_DONE;
        end
      end
      S_ADDSUB: begin
        addOperand1  = r_a;
        addOperand2  = r_b;
        addOperation = r_sub;
        w_next       = S_DONE;
      end
      S_MUL: begin
        addOperand1 = r_hi;
        addOperand2 = r_a;
        if (r_step == 2'd3) w_next = S_DONE;
      end
      S_DIV: begin
        addOperand1  = r_hi;
        addOperand2  = r_b;
        addOperation = 1'b1;
        if (r_b == 4'h0 || !addCarryOut) w_next = S_DONE;
      end
      S_DONE:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  assign addCarryIn = addOperation;
  assign busy       = (r_state != S_IDLE);
  assign done       = (r_state == S_DONE);
  assign result     = r_result;
  assign negative   = r_neg;
  assign errDivZero = r_err;

  // One shift-add step: keep the partial sum only when the multiplier bit is set
  assign w_mc    = r_lo[0] ? addCarryOut : 1'b0;
  assign w_ms    = r_lo[0] ? addSum : r_hi;
  assign w_shift = {w_mc, w_ms, r_lo} >> 1;

  // Datapath and memory
  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      r_sub    <= 1'b0;
      r_a      <= 4'h0;
      r_b      <= 4'h0;
      r_hi     <= 4'h0;
      r_lo     <= 4'h0;
      r_step   <= 2'd0;
      r_result <= 8'h00;
      r_mem    <= MEM_INIT;
      r_neg    <= 1'b0;
      r_err    <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_sub  <= opcode[0];
            r_a    <= operandA;
            r_b    <= operandB;
            r_step <= 2'd0;
            if (opcode == 2'b10) begin
              r_hi <= 4'h0;
              r_lo <= operandB;
            end else begin
              r_hi <= operandA;
              r_lo <= 4'h0;
            end
          end else begin
            case (memCmd)
              c_MEM_STORE: r_mem <= r_result;
              c_MEM_RECALL: begin
                r_result <= r_mem;
                r_neg    <= 1'b0;
                r_err    <= 1'b0;
              end
              c_MEM_CLEAR: r_mem <= MEM_INIT;
              default: ;
            endcase
          end
        end
        S_ADDSUB: begin
          r_err <= 1'b0;
          if (!r_sub) begin
            r_result <= {3'b000, addCarryOut, addSum};
            r_neg    <= 1'b0;
          end else if (addCarryOut) begin
            r_result <= {4'h0, addSum};
            r_neg    <= 1'b0;
          end else begin
            r_result <= {4'hF, addSum};
            r_neg    <= 1'b1;
          end
        end
        S_MUL: begin
          r_hi   <= w_shift[7:4];
          r_lo   <= w_shift[3:0];
          r_step <= r_step + 2'd1;
          if (r_step == 2'd3) begin
            r_result <= w_shift[7:0];
            r_neg    <= 1'b0;
            r_err    <= 1'b0;
          end
        end
        S_DIV: begin
          if (r_b == 4'h0) begin
            r_result <= 8'hFF;
            r_neg    <= 1'b0;
            r_err    <= 1'b1;
          end else if (addCarryOut) begin
            r_hi <= addSum;
            r_lo <= r_lo + 4'd1;
          end else begin
            r_result <= {r_lo, r_hi};
            r_neg    <= 1'b0;
            r_err    <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_calc_sequencer.sv
//==============================================================================
// Module   : tb_calc_sequencer
// Purpose  : Self-checking bench for calc_sequencer with a behavioural adder
//            and an arithmetic reference model.
// Revision : 1.0 - initial release
//==============================================================================
`default_nettype none

module tb_calc_sequencer;

  logic       clk = 1'b0;
  logic       rstN;
  logic       start;
  logic [1:0] opcode;
  logic [3:0] operandA, operandB;
  logic [1:0] memCmd;
  logic [3:0] addOperand1, addOperand2, addSum;
  logic       addOperation, addCarryIn, addCarryOut;
  logic       busy, done, negative, errDivZero;
  logic [7:0] result;
  logic [4:0] w_add;

  int total = 0;
  int bad   = 0;

  // Reference state
  logic [7:0] m_res, m_mem;
  logic       m_neg, m_err;

  calc_sequencer #(.MEM_INIT(8'h00)) dut (
    .clk(clk), .rstN(rstN), .start(start), .opcode(opcode),
    .operandA(operandA), .operandB(operandB), .memCmd(memCmd),
    .addOperand1(addOperand1), .addOperand2(addOperand2),
    .addOperation(addOperation), .addCarryIn(addCarryIn),
    .addSum(addSum), .addCarryOut(addCarryOut),
    .busy(busy), .done(done), .result(result),
    .negative(negative), .errDivZero(errDivZero)
  );

  // 4-bit adder/subtractor: subtract is op1 + ~op2 + carryIn
  assign w_add = {1'b0, addOperand1}
               + {1'b0, (addOperation ? ~addOperand2 : addOperand2)}
               + {4'b0000, addCarryIn};
  assign addSum      = w_add[3:0];
  assign addCarryOut = w_add[4];

  always #5 clk = ~clk;

  task automatic check(input string tag, input int got, input int exp);
    total++;
    if (got != exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic do_op(input logic [1:0] op, input logic [3:0] a, input logic [3:0] b,
                       input logic [1:0] mc, input bit poke);
    logic [7:0] e_res;
    logic       e_neg, e_err;
    int         e_lat, diff, q, r, cyc;
    e_neg = 1'b0;
    e_err = 1'b0;
    e_lat = 2;
    case (op)
      2'b00: e_res = {4'h0, a} + {4'h0, b};
      2'b01: begin
        diff  = int'(a) - int'(b);
        e_res = diff[7:0];
        e_neg = (diff < 0);
      end
      2'b10: begin
        e_res = {4'h0, a} * {4'h0, b};
        e_lat = 5;
      end
      default: begin
        if (b == 4'h0) begin
          e_res = 8'hFF;
          e_err = 1'b1;
        end else begin
          q     = int'(a) / int'(b);
          r     = int'(a) % int'(b);
          e_res = {q[3:0], r[3:0]};
          e_lat = q + 2;
        end
      end
    endcase

    @(negedge clk);
    start = 1'b1; opcode = op; operandA = a; operandB = b; memCmd = mc;
    @(negedge clk);
    start = 1'b0; memCmd = 2'b00;
    cyc = 1;
    if (!op[1]) begin
      check("addOperation", int'(addOperation), int'(op[0]));
      check("addCarryIn", int'(addCarryIn), int'(op[0]));
    end
    while (!done && cyc < 40) begin
      @(negedge clk);
      cyc++;
      start = poke && (cyc == 2);
      if (start) begin
        opcode   = 2'($urandom_range(0, 3));
        operandA = 4'($urandom);
        operandB = 4'($urandom);
      end
    end
    start = 1'b0;
    check("latency", cyc, e_lat);
    check("result", int'(result), int'(e_res));
    check("negative", int'(negative), int'(e_neg));
    check("errDivZero", int'(errDivZero), int'(e_err));
    m_res = e_res;
    m_neg = e_neg;
    m_err = e_err;
    @(negedge clk);
    check("done_pulse", int'(done), 0);
    check("idle_busy", int'(busy), 0);
  endtask

  task automatic do_mem(input logic [1:0] mc);
    @(negedge clk);
    memCmd = mc;
    @(negedge clk);
    memCmd = 2'b00;
    case (mc)
      2'b01: m_mem = m_res;
      2'b10: begin m_res = m_mem; m_neg = 1'b0; m_err = 1'b0; end
      2'b11: m_mem = 8'h00;
      default: ;
    endcase
    if (mc == 2'b10) begin
      check("recall_done", int'(done), 1);
      check("recall_busy", int'(busy), 1);
      check("recall_result", int'(result), int'(m_res));
      check("recall_neg", int'(negative), 0);
      check("recall_err", int'(errDivZero), 0);
      @(negedge clk);
      check("recall_done_end", int'(done), 0);
    end else begin
      check("mem_no_done", int'(done), 0);
      check("mem_result_held", int'(result), int'(m_res));
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rstN = 1'b0; start = 1'b0; opcode = 2'b00;
    operandA = 4'h0; operandB = 4'h0; memCmd = 2'b00;
    m_res = 8'h00; m_mem = 8'h00; m_neg = 1'b0; m_err = 1'b0;
    #12;
    check("rst_busy", int'(busy), 0);
    check("rst_done", int'(done), 0);
    check("rst_result", int'(result), 0);
    check("rst_neg", int'(negative), 0);
    check("rst_err", int'(errDivZero), 0);
    check("rst_op1", int'(addOperand1), 0);
    @(negedge clk);
    rstN = 1'b1;

    // Directed cases
    do_op(2'b00, 4'd9, 4'd8, 2'b00, 1'b0);
    do_op(2'b01, 4'd3, 4'd5, 2'b00, 1'b0);
    do_op(2'b01, 4'd5, 4'd3, 2'b00, 1'b0);
    do_op(2'b10, 4'd15, 4'd15, 2'b00, 1'b1);
    do_op(2'b10, 4'd0, 4'd7, 2'b00, 1'b0);
    do_op(2'b11, 4'd13, 4'd4, 2'b00, 1'b0);
    do_op(2'b11, 4'd15, 4'd1, 2'b00, 1'b0);
    do_op(2'b11, 4'd2, 4'd5, 2'b00, 1'b0);
    do_op(2'b11, 4'd6, 4'd0, 2'b00, 1'b0);

    // Memory sequence
    do_op(2'b00, 4'd7, 4'd6, 2'b00, 1'b0);
    do_mem(2'b01);
    do_op(2'b01, 4'd1, 4'd2, 2'b00, 1'b0);
    do_mem(2'b10);
    do_mem(2'b11);
    do_mem(2'b10);
    do_op(2'b00, 4'd4, 4'd4, 2'b00, 1'b0);
    do_op(2'b00, 4'd1, 4'd3, 2'b01, 1'b0);   // store dropped: start wins
    do_mem(2'b10);

    // Randomized operations and memory commands
    for (int i = 0; i < 60; i++) begin
      if ($urandom_range(0, 4) == 0)
        do_mem(2'($urandom_range(1, 3)));
      else
        do_op(2'($urandom_range(0, 3)), 4'($urandom), 4'($urandom),
              2'($urandom), 1'($urandom));
    end

    // Asynchronous reset during the second multiply cycle
    do_op(2'b00, 4'd5, 4'd5, 2'b00, 1'b0);
    do_mem(2'b01);
    @(negedge clk);
    start = 1'b1; opcode = 2'b10; operandA = 4'd9; operandB = 4'd9;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    #2;
    rstN = 1'b0;
    #1;
    check("arst_busy", int'(busy), 0);
    check("arst_done", int'(done), 0);
    check("arst_result", int'(result), 0);
    check("arst_neg", int'(negative), 0);
    check("arst_err", int'(errDivZero), 0);
    m_res = 8'h00; m_mem = 8'h00; m_neg = 1'b0; m_err = 1'b0;
    @(negedge clk);
    rstN = 1'b1;
    do_mem(2'b10);
    do_op(2'b00, 4'd1, 4'd1, 2'b00, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
